// File: rtl/mmr_vote_pkg.sv
// Shared types and helpers for the modular-redundancy vote stage.
// Helpers take a fixed-width vector; callers zero-extend their K-wide replica vectors.
package mmr_vote_pkg;

  localparam int MAX_K     = 15;
  localparam int MAX_IDX_W = 4;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_REPORT = 1'b1
  } rpt_state_t;

  function automatic logic majority(input logic [MAX_K-1:0] bits, input int unsigned k);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < MAX_K; i++) begin
      if (bits[i]) ones++;
    end
    return (ones > (k / 2));
  endfunction

  function automatic logic [MAX_IDX_W-1:0] lowest_set(input logic [MAX_K-1:0] vec);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_K - 1; i >= 0; i--) begin
      if (vec[i]) idx = MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mmr_sat_counter.sv
// Saturating event counter; increments by one per cycle with inc_i, sticks at all-ones.
// One cycle latency, synchronous clear has priority over increment, no backpressure.
module mmr_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 inc_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/mmr_vote_stage.sv
// Bitwise majority vote over K replicas with per-replica fault counters and a fault-record port.
// One cycle vote latency; the record holds while report_ready_i is low and overflow sets report_lost_o.
module mmr_vote_stage
  import mmr_vote_pkg::*;
#(
  parameter int K_MMR     = 3,
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic [K_MMR-1:0][WIDTH-1:0]          data_i,
  input  logic                                 valid_i,
  input  logic                                 clear_i,
  output logic [WIDTH-1:0]                     voted_o,
  output logic                                 voted_valid_o,
  output logic                                 mismatch_o,
  output logic [K_MMR-1:0][CNT_WIDTH-1:0]      fault_cnt_o,
  output logic                                 report_valid_o,
  input  logic                                 report_ready_i,
  output logic [$clog2(K_MMR)-1:0]             report_replica_o,
  output logic [WIDTH-1:0]                     report_bits_o,
  output logic                                 report_lost_o
);

  localparam int RW = $clog2(K_MMR);

  if ((K_MMR < 3) || ((K_MMR % 2) == 0) || (K_MMR > MAX_K)) begin : g_bad_k
    $error("mmr_vote_stage: K_MMR must be odd, >= 3 and <= MAX_K");
  end

  logic [WIDTH-1:0] w_vote;
  logic [MAX_K-1:0] w_col;
  logic [K_MMR-1:0] w_faulty;
  logic             w_any;
  logic [RW-1:0]    w_low;
  logic [WIDTH-1:0] w_bits;

  always_comb begin
    w_vote = '0;
    w_col  = '0;
    for (int b = 0; b < WIDTH; b++) begin
      w_col = '0;
      for (int r = 0; r < K_MMR; r++) w_col[r] = data_i[r][b];
      w_vote[b] = majority(w_col, K_MMR);
    end
  end

  // Faulty flags are already qualified by valid_i, so counters and FSM need no extra gating.
  always_comb begin
    w_faulty = '0;
    for (int r = 0; r < K_MMR; r++) w_faulty[r] = valid_i && (data_i[r] != w_vote);
  end

  assign w_any  = |w_faulty;
  assign w_low  = RW'(lowest_set(MAX_K'(w_faulty)));
  assign w_bits = data_i[w_low] ^ w_vote;

  for (genvar r = 0; r < K_MMR; r++) begin : g_cnt
    mmr_sat_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .inc_i  (w_faulty[r]),
      .clr_i  (clear_i),
      .cnt_o  (fault_cnt_o[r])
    );
  end

  logic [WIDTH-1:0] r_voted;
  logic             r_voted_vld;
  logic             r_mismatch;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_voted     <= '0;
      r_voted_vld <= 1'b0;
      r_mismatch  <= 1'b0;
    end else begin
      if (valid_i) r_voted <= w_vote;
      r_voted_vld <= valid_i;
      r_mismatch  <= w_any;
    end
  end

  rpt_state_t       r_state;
  logic [RW-1:0]    r_rep_idx;
  logic [WIDTH-1:0] r_rep_bits;
  logic             r_lost;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_rep_idx  <= '0;
      r_rep_bits <= '0;
      r_lost     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state    <= S_REPORT;
            r_rep_idx  <= w_low;
            r_rep_bits <= w_bits;
          end
        end
        S_REPORT: begin
          if (report_ready_i) begin
            if (w_any) begin
              r_rep_idx  <= w_low;
              r_rep_bits <= w_bits;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_any) begin
            r_lost <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (clear_i) r_lost <= 1'b0;
    end
  end

  assign voted_o          = r_voted;
  assign voted_valid_o    = r_voted_vld;
  assign mismatch_o       = r_mismatch;
  assign report_valid_o   = (r_state == S_REPORT);
  assign report_replica_o = r_rep_idx;
  assign report_bits_o    = r_rep_bits;
  assign report_lost_o    = r_lost;

endmodule

// File: tb/tb_mmr_vote_stage.sv
// Directed bench for mmr_vote_stage: default instance plus a 4-bit-counter instance on shared stimulus.
module tb_mmr_vote_stage;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic             rst_n_i;
  logic [2:0][7:0]  data_i;
  logic             valid_i;
  logic             clear_i;
  logic             report_ready_i;

  logic [7:0]       voted;
  logic             voted_vld;
  logic             mism;
  logic [2:0][15:0] cnt;
  logic             rvld;
  logic [1:0]       rrep;
  logic [7:0]       rbits;
  logic             rlost;

  logic [7:0]       s_voted;
  logic             s_voted_vld;
  logic             s_mism;
  logic [2:0][3:0]  s_cnt;
  logic             s_rvld;
  logic [1:0]       s_rrep;
  logic [7:0]       s_rbits;
  logic             s_rlost;

  mmr_vote_stage #(.K_MMR(3), .WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i), .valid_i(valid_i), .clear_i(clear_i),
    .voted_o(voted), .voted_valid_o(voted_vld), .mismatch_o(mism), .fault_cnt_o(cnt),
    .report_valid_o(rvld), .report_ready_i(report_ready_i), .report_replica_o(rrep),
    .report_bits_o(rbits), .report_lost_o(rlost)
  );

  mmr_vote_stage #(.K_MMR(3), .WIDTH(8), .CNT_WIDTH(4)) dut_sat (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i), .valid_i(valid_i), .clear_i(clear_i),
    .voted_o(s_voted), .voted_valid_o(s_voted_vld), .mismatch_o(s_mism), .fault_cnt_o(s_cnt),
    .report_valid_o(s_rvld), .report_ready_i(report_ready_i), .report_replica_o(s_rrep),
    .report_bits_o(s_rbits), .report_lost_o(s_rlost)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_voted"}, voted, 8'h00);
    chk({tag, "_vvld"}, voted_vld, 1'b0);
    chk({tag, "_mism"}, mism, 1'b0);
    chk({tag, "_cnt0"}, cnt[0], 16'd0);
    chk({tag, "_cnt1"}, cnt[1], 16'd0);
    chk({tag, "_cnt2"}, cnt[2], 16'd0);
    chk({tag, "_rvld"}, rvld, 1'b0);
    chk({tag, "_rrep"}, rrep, 2'd0);
    chk({tag, "_rbits"}, rbits, 8'h00);
    chk({tag, "_lost"}, rlost, 1'b0);
  endtask

  initial begin
    rst_n_i        = 1'b0;
    data_i         = '0;
    valid_i        = 1'b0;
    clear_i        = 1'b0;
    report_ready_i = 1'b0;
    #2;
    chk_reset_state("rst");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step();

    // clean sample
    data_i  = {8'hA5, 8'hA5, 8'hA5};
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("clean_voted", voted, 8'hA5);
    chk("clean_vvld", voted_vld, 1'b1);
    chk("clean_mism", mism, 1'b0);
    chk("clean_cnt1", cnt[1], 16'd0);
    chk("clean_rvld", rvld, 1'b0);
    step();
    chk("idle_vvld", voted_vld, 1'b0);
    chk("idle_hold", voted, 8'hA5);

    // replica 1 corrupt, record held with ready low
    data_i  = {8'h3C, 8'h00, 8'h3C};
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("r1_voted", voted, 8'h3C);
    chk("r1_mism", mism, 1'b1);
    chk("r1_cnt1", cnt[1], 16'd1);
    chk("r1_cnt0", cnt[0], 16'd0);
    chk("r1_rvld", rvld, 1'b1);
    chk("r1_rrep", rrep, 2'd1);
    chk("r1_rbits", rbits, 8'h3C);
    chk("r1_lost", rlost, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_rvld", rvld, 1'b1);
      chk("hold_rrep", rrep, 2'd1);
      chk("hold_rbits", rbits, 8'h3C);
    end
    chk("hold_mism", mism, 1'b0);
    report_ready_i = 1'b1;
    step();
    report_ready_i = 1'b0;
    chk("hs_rvld", rvld, 1'b0);

    // lost record, then back-to-back handshake
    data_i  = {8'h3C, 8'h00, 8'h3C};
    valid_i = 1'b1;
    step();
    chk("r1b_cnt1", cnt[1], 16'd2);
    chk("r1b_rvld", rvld, 1'b1);
    data_i = {8'h3D, 8'h3C, 8'h3C};
    step();
    valid_i = 1'b0;
    chk("lost_voted", voted, 8'h3C);
    chk("lost_cnt2", cnt[2], 16'd1);
    chk("lost_rrep", rrep, 2'd1);
    chk("lost_rbits", rbits, 8'h3C);
    chk("lost_flag", rlost, 1'b1);
    data_i         = {8'h3C, 8'h3C, 8'h3E};
    valid_i        = 1'b1;
    report_ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("b2b_rvld", rvld, 1'b1);
    chk("b2b_rrep", rrep, 2'd0);
    chk("b2b_rbits", rbits, 8'h02);
    chk("b2b_cnt0", cnt[0], 16'd1);
    step();
    report_ready_i = 1'b0;
    chk("b2b_drain", rvld, 1'b0);

    // saturation on replica 0 (4-bit instance), starting from 1
    data_i  = {8'h00, 8'h00, 8'hFF};
    valid_i = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt0", s_cnt[0], 4'd15);
    chk("wide_cnt0", cnt[0], 16'd21);
    chk("sat_rrep", rrep, 2'd0);
    chk("sat_rbits", rbits, 8'hFF);
    step();
    step();
    chk("sat_hold", s_cnt[0], 4'd15);
    chk("wide_cnt0b", cnt[0], 16'd23);
    chk("sat_lost", rlost, 1'b1);

    // clear coincident with a faulty sample
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    valid_i = 1'b0;
    chk("clr_cnt0", cnt[0], 16'd0);
    chk("clr_scnt0", s_cnt[0], 4'd0);
    chk("clr_cnt1", cnt[1], 16'd0);
    chk("clr_cnt2", cnt[2], 16'd0);
    chk("clr_lost", rlost, 1'b0);
    chk("clr_rvld", rvld, 1'b1);

    // build nonzero state, then asynchronous reset mid-report
    data_i  = {8'h5A, 8'hA5, 8'h5A};
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("pre_voted", voted, 8'h5A);
    chk("pre_cnt1", cnt[1], 16'd1);
    chk("pre_lost", rlost, 1'b1);
    chk("pre_rbits", rbits, 8'hFF);
    @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_reset_state("arst");
    chk("arst_scnt0", s_cnt[0], 4'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    data_i  = {8'h77, 8'h77, 8'h77};
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("post_voted", voted, 8'h77);
    chk("post_vvld", voted_vld, 1'b1);
    chk("post_mism", mism, 1'b0);
    chk("post_rvld", rvld, 1'b0);
    chk("post_cnt1", cnt[1], 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmr_vote_stage.md
# mmr_vote_stage

Registered majority-vote stage placed directly downstream of the K-modular redundant register bank. It consumes the K replicas of a W-bit register word and drives one voted word to the fabric. It keeps a saturating fault counter for each replica and emits one fault record at a time through a valid/ready handshake to the monitoring/scrub logic. It provides the real voting and diagnostics that the no-vote register variant omits.

## Interface
- K_MMR, 3, replica count; must be odd and ≥3 (elaboration error otherwise)
- WIDTH, 8, bits per replica word
- CNT_WIDTH, 16, width of each per-replica fault counter
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- data_i  in  K_MMR×WIDTH  replica words, index 0..K_MMR-1
- valid_i  in  1  sample strobe for data_i
- clear_i  in  1  synchronous clear of counters and lost flag
- voted_o  out  WIDTH  majority-voted word
- voted_valid_o  out  1  voted_o updated this cycle
- mismatch_o  out  1  one-cycle pulse: the sample just voted had ≥1 disagreeing replica
- fault_cnt_o  out  K_MMR×CNT_WIDTH  per-replica faulty-sample counters
- report_valid_o  out  1  fault record pending
- report_ready_i  in  1  consumer accepts record
- report_replica_o  out  $clog2(K_MMR)  index of the reported faulty replica
- report_bits_o  out  WIDTH  data_i[replica] XOR voted word (the flipped bits)
- report_lost_o  out  1  sticky: a faulty sample arrived while a record was pending

## Operation
- Vote: each bit of the voted word is 1 when more than K_MMR/2 replicas carry 1 for that bit. Odd K_MMR guarantees no ties.
- A replica r is faulty for a sample when data_i[r] ≠ voted word. This comparison is made only on valid_i samples.
- Counters: fault_cnt[r] increments by 1 for each faulty sample, not for each bit. It saturates at 2^CNT_WIDTH−1. When clear_i and an increment occur in the same cycle, clear wins and the result is 0.
- Report FSM has two states, IDLE and REPORT.
  - IDLE → REPORT: a valid_i sample with any faulty replica. The FSM captures the lowest-index faulty replica and its XOR bits.
  - REPORT → IDLE: report_valid_o & report_ready_i, with no new faulty sample in that cycle.
  - Handshake cycle with a new faulty sample: the FSM stays in REPORT and captures the new record (back-to-back records, no bubble).
  - Faulty sample arriving in REPORT without a handshake: the record is unchanged, the counters still increment, and report_lost_o is set.
- The record stays stable while report_valid_o=1 and report_ready_i=0.
- report_lost_o clears only on clear_i or reset.
- Reset values: voted_o=0, voted_valid_o=0, mismatch_o=0, all counters 0, FSM IDLE, report_valid_o=0, report_replica_o=0, report_bits_o=0, report_lost_o=0.

## Timing
- Voting and fault flags use one cycle of latency. A sample with valid_i at cycle n produces voted_o, voted_valid_o, mismatch_o and the counter increment at cycle n+1.
- report_valid_o rises at n+1, in the same cycle as mismatch_o.
- While valid_i=0, voted_o holds its last value, and voted_valid_o and mismatch_o are 0.
- Reset assertion clears all state immediately, independent of clk_i. This holds mid-report; any pending record is dropped. Deassertion is synchronised externally.
- clear_i takes effect on the next edge; fault_cnt_o reads 0 at n+1.

## Structure
- Package mmr_vote_pkg contains:
  - the FSM state enum (IDLE, REPORT)
  - the function majority(bits[K_MMR-1:0]) → bit
  - the function lowest_set(vector) → index
- Sub-module mmr_sat_counter (CNT_WIDTH, inc_i, clr_i, cnt_o) holds one saturating counter and is instantiated K_MMR times.
- The top level contains the vote, comparators, FSM and report registers.

## Test plan
Default parameters (K_MMR=3, WIDTH=8) unless stated.
- All replicas 0xA5, valid_i for 1 cycle → next cycle voted_o=0xA5, voted_valid_o=1, mismatch_o=0, counters 0, report_valid_o=0.
- data_i={0x3C,0x00,0x3C} (replica 1 corrupt) → voted_o=0x3C, mismatch_o pulse, fault_cnt[1]=1, report_replica_o=1, report_bits_o=0x3C. The record is held for 5 cycles with ready low, and report_valid_o drops the cycle after ready=1.
- Record pending with ready low, then replica 2 = 0x3D vs 0x3C → fault_cnt[2]=1, record still replica 1, report_lost_o=1. Handshake in the same cycle as a new faulty sample → record switches with report_valid_o continuously 1.
- CNT_WIDTH=4, 20 consecutive faulty samples on replica 0 → fault_cnt[0]=15 and holds. clear_i coincident with a faulty sample → 0, report_lost_o=0.
- rst_n_i pulled low mid-REPORT, between clock edges → all outputs read their reset values before the next edge. After release, a clean sample produces a normal vote.
